// File: rtl/calibration_sequencer.sv
// Calibration code sequencer: steps out_port through 0..LAST with a programmable
// dwell per code and an optional per-step ack handshake, controlled over Avalon-MM.
module calibration_sequencer #(
    parameter int DWELL_W = 16,
    parameter int OUT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [OUT_W-1:0] out_port,
    output logic             step_valid,
    input  logic             step_ack,
    output logic             irq
);

    // state    | meaning
    // IDLE     | no sequence running, out_port parked at 0
    // HOLD     | presenting code, dwell counter running
    // WAIT_ACK | dwell expired, waiting for target to accept code
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   code, code_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;

    logic               ctrl_loop, ctrl_ack_en, ctrl_irq_en;
    logic [DWELL_W-1:0] dwell_reg;
    logic [OUT_W-1:0]   steps_reg;
    logic               done;

    logic               wr, wr_ctrl, wr_dwell, wr_steps, wr_status;
    logic               start, abort, start_go, done_set;
    logic [DWELL_W-1:0] dwell_eff;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr & (address == 2'd0);
    assign wr_dwell  = wr & (address == 2'd1);
    assign wr_steps  = wr & (address == 2'd2);
    assign wr_status = wr & (address == 2'd3);
    assign start     = wr_ctrl & writedata[0];
    assign abort     = wr_ctrl & writedata[1];

    // A programmed dwell of zero still holds each code for one cycle
    assign dwell_eff = (dwell_reg == '0) ? DWELL_W'(1) : dwell_reg;

    // Upper write-data bits have no register behind them
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:DWELL_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            code  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        cnt_nxt   = cnt;
        done_set  = 1'b0;
        start_go  = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            code_nxt  = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        start_go  = 1'b1;
                        state_nxt = S_HOLD;
                        code_nxt  = '0;
                        cnt_nxt   = dwell_eff;
                    end
                end
                S_HOLD: begin
                    if (cnt <= DWELL_W'(1)) begin
                        if (ctrl_ack_en) begin
                            state_nxt = S_WAIT_ACK;
                        end else if (code < steps_reg) begin
                            state_nxt = S_HOLD;
                            code_nxt  = code + OUT_W'(1);
                            cnt_nxt   = dwell_eff;
                        end else if (ctrl_loop) begin
                            state_nxt = S_HOLD;
                            code_nxt  = '0;
                            cnt_nxt   = dwell_eff;
                        end else begin
                            state_nxt = S_IDLE;
                            code_nxt  = '0;
                            cnt_nxt   = '0;
                            done_set  = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt - DWELL_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (step_ack) begin
                        if (code < steps_reg) begin
                            state_nxt = S_HOLD;
                            code_nxt  = code + OUT_W'(1);
                            cnt_nxt   = dwell_eff;
                        end else if (ctrl_loop) begin
                            state_nxt = S_HOLD;
                            code_nxt  = '0;
                            cnt_nxt   = dwell_eff;
                        end else begin
                            state_nxt = S_IDLE;
                            code_nxt  = '0;
                            cnt_nxt   = '0;
                            done_set  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    code_nxt  = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Register file; DONE set by sequence completion outranks a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_loop   <= 1'b0;
            ctrl_ack_en <= 1'b0;
            ctrl_irq_en <= 1'b0;
            dwell_reg   <= '0;
            steps_reg   <= '0;
            done        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_loop   <= writedata[2];
                ctrl_ack_en <= writedata[3];
                ctrl_irq_en <= writedata[4];
            end
            if (wr_dwell) dwell_reg <= writedata[DWELL_W-1:0];
            if (wr_steps) steps_reg <= writedata[OUT_W-1:0];
            if (done_set)
                done <= 1'b1;
            else if (start_go || wr_status)
                done <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[2] = ctrl_loop;
                readdata[3] = ctrl_ack_en;
                readdata[4] = ctrl_irq_en;
            end
            2'd1: readdata[DWELL_W-1:0] = dwell_reg;
            2'd2: readdata[OUT_W-1:0]   = steps_reg;
            2'd3: begin
                readdata[0]          = (state != S_IDLE);
                readdata[1]          = done;
                readdata[8 +: OUT_W] = code;
            end
            default: readdata = '0;
        endcase
    end

    assign out_port   = (state == S_IDLE) ? '0 : code;
    assign step_valid = (state == S_WAIT_ACK);
    assign irq        = done & ctrl_irq_en;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Directed bench for calibration_sequencer: table of dwell/step runs plus
// hand-written ack, loop/abort, irq and reset sequences.
module tb_calibration_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  out_port;
    logic        step_valid;
    logic        step_ack;
    logic        irq;

    int checks = 0;
    int errors = 0;

    calibration_sequencer #(.DWELL_W(16), .OUT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .step_valid (step_valid),
        .step_ack   (step_ack),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        int len;
        int status_code;
        int sv_cycles;
    } run_t;

    typedef struct {
        logic [15:0] dwell;
        logic [2:0]  steps;
        int          exp_len;
        int          exp_n;
    } vec_t;

    run_t runs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write is captured at the next posedge, returns at the following negedge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    // Records (code, cycles held) runs until BUSY drops; answers step_valid
    // after one cycle, or after code1_delay cycles while code 1 is presented
    task automatic capture(input int code1_delay, input int budget, output bit timeout);
        int          wcnt;
        int          cyc;
        int          last;
        logic [31:0] st;
        run_t        r;
        wcnt    = 0;
        cyc     = 0;
        timeout = 1'b1;
        runs.delete();
        address = 2'd3;
        while (cyc < budget) begin
            #1;
            st = readdata;
            if (!st[0]) begin
                timeout = 1'b0;
                break;
            end
            if (runs.size() == 0 || runs[runs.size()-1].code != int'(out_port)) begin
                r.code        = int'(out_port);
                r.len         = 1;
                r.status_code = int'(st[10:8]);
                r.sv_cycles   = 0;
                runs.push_back(r);
            end else begin
                last = runs.size() - 1;
                runs[last].len = runs[last].len + 1;
            end
            if (step_valid) begin
                last = runs.size() - 1;
                runs[last].sv_cycles = runs[last].sv_cycles + 1;
                wcnt++;
                step_ack = (wcnt >= ((out_port == 3'd1) ? code1_delay : 1));
            end else begin
                wcnt     = 0;
                step_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        step_ack = 1'b0;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] rd;
        bit          to;
        int          n;

        vecs[0] = '{dwell: 16'd4, steps: 3'd2, exp_len: 4, exp_n: 3};
        vecs[1] = '{dwell: 16'd0, steps: 3'd7, exp_len: 1, exp_n: 8};
        vecs[2] = '{dwell: 16'd1, steps: 3'd0, exp_len: 1, exp_n: 1};
        vecs[3] = '{dwell: 16'd3, steps: 3'd5, exp_len: 3, exp_n: 6};
        vecs[4] = '{dwell: 16'd2, steps: 3'd3, exp_len: 2, exp_n: 4};

        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        step_ack   = 1'b0;
        repeat (3) @(negedge clk);

        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            check($sformatf("reset_reg%0d", a), rd, 32'h0);
        end
        check("reset_out_port", {29'b0, out_port}, 32'h0);
        check("reset_step_valid", {31'b0, step_valid}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Plain runs: every code 0..LAST held max(DWELL,1) cycles, then DONE
        for (int v = 0; v < 5; v++) begin
            bus_write(2'd1, {16'b0, vecs[v].dwell});
            bus_write(2'd2, {29'b0, vecs[v].steps});
            bus_write(2'd0, 32'h1);
            capture(1, 300, to);
            check($sformatf("v%0d_timeout", v), {31'b0, to}, 32'h0);
            check($sformatf("v%0d_num_codes", v), runs.size(), vecs[v].exp_n);
            for (int i = 0; i < runs.size(); i++) begin
                check($sformatf("v%0d_code%0d", v, i), runs[i].code, i);
                check($sformatf("v%0d_len%0d", v, i), runs[i].len, vecs[v].exp_len);
                check($sformatf("v%0d_status_code%0d", v, i), runs[i].status_code, i);
            end
            bus_read(2'd3, rd);
            check($sformatf("v%0d_status_end", v), rd, 32'h2);
            check($sformatf("v%0d_out_idle", v), {29'b0, out_port}, 32'h0);
            @(negedge clk);
        end

        // Ack handshake, code 1 acked 5 cycles late
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h9);
        capture(5, 300, to);
        check("ack_timeout", {31'b0, to}, 32'h0);
        check("ack_num_codes", runs.size(), 3);
        if (runs.size() == 3) begin
            check("ack_len0", runs[0].len, 3);
            check("ack_len1", runs[1].len, 7);
            check("ack_len2", runs[2].len, 3);
            check("ack_valid1", runs[1].sv_cycles, 5);
            check("ack_code2", runs[2].code, 2);
        end
        bus_read(2'd3, rd);
        check("ack_status_end", rd, 32'h2);
        @(negedge clk);

        // Loop with abort on the 11th cycle
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'h5);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("loop_cyc%0d", i), {29'b0, out_port}, (i / 3) % 2);
            @(negedge clk);
        end
        check("loop_cyc10", {29'b0, out_port}, 32'h1);
        bus_write(2'd0, 32'h2);
        check("abort_out_port", {29'b0, out_port}, 32'h0);
        check("abort_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd);
        check("abort_status", rd, 32'h0);
        @(negedge clk);

        // IRQ, START while busy, clear, DONE set vs clear collision, START+ABORT
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'h11);
        check("irq_run_c0", {29'b0, out_port}, 32'h0);
        check("irq_low_busy", {31'b0, irq}, 32'h0);
        @(negedge clk);
        bus_write(2'd0, 32'h11);
        check("restart_ignored", {29'b0, out_port}, 32'h1);
        @(negedge clk);
        check("irq_run_c1_last", {29'b0, out_port}, 32'h1);
        @(negedge clk);
        bus_read(2'd3, rd);
        check("irq_status_done", rd, 32'h2);
        check("irq_high", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h0);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd);
        check("status_cleared", rd, 32'h0);
        @(negedge clk);
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h11);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd);
        check("done_set_wins", rd, 32'h2);
        check("done_set_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        bus_write(2'd0, 32'h3);
        bus_read(2'd3, rd);
        check("start_abort_same", rd, 32'h2);
        @(negedge clk);

        // Reset during HOLD of code 3
        bus_write(2'd1, 32'd5);
        bus_write(2'd2, 32'd5);
        bus_write(2'd0, 32'h15);
        n = 0;
        while (out_port != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_code3", {29'b0, out_port}, 32'h3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_port", {29'b0, out_port}, 32'h0);
        check("rst_step_valid", {31'b0, step_valid}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            check($sformatf("rst_reg%0d", a), rd, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_out_port", {29'b0, out_port}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
